// File: rtl/slot_sched_pkg.sv
// Shared types and helpers for the slot scheduler: FSM state encoding,
// slot-table geometry, the power-up slot ownership pattern and a one-hot
// encoder.
package slot_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;

   // Power-up owner of a slot: owners repeat round the requesters.
   function automatic logic [SLOT_W-1:0] default_owner(input int slot_idx, input int num_req);
      return SLOT_W'(slot_idx % num_req);
   endfunction

   // One-hot encode a requester index into a NUM_SLOTS-wide vector.
   function automatic logic [NUM_SLOTS-1:0] onehot(input logic [SLOT_W-1:0] idx);
      logic [NUM_SLOTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/slot_scheduler_rr_picker.sv
// Round-robin picker: returns the first requesting index found scanning
// upward from ptr_i (mod N). Used only by the work-conserving reclaim path.
module rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         valid_o,
   output logic [W-1:0] winner_o
);

   logic [W-1:0] idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      idx      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = W'((int'(ptr_i) + k) % N);
         if (req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/slot_scheduler.sv
// Time-slot scheduler: an 8-entry owner table walked by a mod-8 slot counter
// hands a registered one-hot grant to the slot owner, held until done or
// hold expiry. Optional macro SLOT_RECLAIM_EN makes the scheduler
// work-conserving: an unrequested slot is reclaimed by a round-robin pick.
module slot_scheduler
   import slot_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         done,
   input  logic                       cfg_we,
   input  logic [2:0]                 cfg_slot,
   input  logic [$clog2(NUM_REQ)-1:0] cfg_owner,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy,
   output logic [2:0]                 slot,
   output logic                       timeout
);

   localparam int OW = $clog2(NUM_REQ);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 busy_q, busy_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic                 timeout_q, timeout_d;
   logic [3:0]           hold_q, hold_d;
   logic [OW-1:0]        gidx_q, gidx_d;
   logic [OW-1:0]        table_q [NUM_SLOTS];
   logic [OW-1:0]        owner;
   logic [NUM_SLOTS-1:0] grant_full;
   logic                 cfg_ok;

   assign owner  = table_q[slot_q];
   assign cfg_ok = ({1'b0, cfg_owner} < (OW+1)'(NUM_REQ));

`ifdef SLOT_RECLAIM_EN
   logic [OW-1:0] ptr_q, ptr_d;
   logic          pick_valid;
   logic [OW-1:0] pick_idx;

   rr_picker #(.N(NUM_REQ), .W(OW)) u_rr_picker (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_idx)
   );
`endif

   // Next-state logic: grant the owner, reclaim or skip in IDLE; release on done or hold expiry in GRANT.
   always_comb begin
      state_d    = state_q;
      gidx_d     = gidx_q;
      hold_d     = hold_q;
      slot_d     = slot_q;
      timeout_d  = 1'b0;
      grant_full = '0;
      grant_d    = '0;
`ifdef SLOT_RECLAIM_EN
      ptr_d      = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req[owner]) begin
               state_d = GRANT;
               gidx_d  = owner;
               hold_d  = 4'd1;
            end
`ifdef SLOT_RECLAIM_EN
            else if (pick_valid) begin
               state_d = GRANT;
               gidx_d  = pick_idx;
               hold_d  = 4'd1;
               ptr_d   = OW'((int'(pick_idx) + 1) % NUM_REQ);
            end
`endif
            else begin
               slot_d = slot_q + 3'd1;
            end
         end
         GRANT: begin
            if (done[gidx_q] || (hold_q == 4'(HOLD_MAX))) begin
               state_d   = IDLE;
               hold_d    = 4'd0;
               slot_d    = slot_q + 3'd1;
               timeout_d = ~done[gidx_q];
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == GRANT) begin
         grant_full = onehot(SLOT_W'(gidx_d));
         grant_d    = grant_full[NUM_REQ-1:0];
      end
      busy_d = |grant_d;
   end

   // Control and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         slot_q    <= '0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         gidx_q    <= '0;
`ifdef SLOT_RECLAIM_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         slot_q    <= slot_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         gidx_q    <= gidx_d;
`ifdef SLOT_RECLAIM_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   // Slot owner table: reset to defaults, written when the new owner is in range.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            table_q[i] <= OW'(default_owner(i, NUM_REQ));
         end
      end else if (cfg_we && cfg_ok) begin
         table_q[cfg_slot] <= cfg_owner;
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign slot    = slot_q;
   assign timeout = timeout_q;

endmodule

// File: doc/slot_scheduler.md
# slot_scheduler

Time-slot scheduler that shares one downstream resource among `NUM_REQ` requesters using an 8-entry slot table walked by a mod-8 slot counter. Each slot has an owning requester. If the owner is requesting, it receives a one-hot grant held until `done` or a hold timeout. The block sits between the requester agents and the shared counter/datapath resource and is the only source of `grant`.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `HOLD_MAX`, 4: maximum consecutive granted cycles; 1..15.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `req`  input  NUM_REQ: level request per requester.
- `done`  input  NUM_REQ: release strobe from the granted requester.
- `cfg_we`  input  1: slot-table write enable.
- `cfg_slot`  input  3: slot index to write.
- `cfg_owner`  input  $clog2(NUM_REQ): new owner for `cfg_slot`.
- `grant`  output  NUM_REQ: registered one-hot grant; all-zero when idle.
- `busy`  output  1: high while any grant is active.
- `slot`  output  3: current slot counter value.
- `timeout`  output  1: one-cycle pulse when a grant ends by hold expiry.

## Operation
- FSM states: IDLE and GRANT.
- Reset (`reset`=0) values: `grant`=0, `busy`=0, `slot`=0, `timeout`=0, state IDLE, hold counter 0, round-robin pointer 0. Slot table entry i = i mod NUM_REQ.
- IDLE, owner = table[slot]:
  - `req[owner]`=1: go to GRANT, `grant`=onehot(owner), hold counter=1, `slot` unchanged.
  - Otherwise: reclaim path (see Configuration). If nothing is granted, `slot` <= slot+1 mod 8.
- GRANT, g = granted index:
  - Release when `done[g]`=1 or hold counter == HOLD_MAX. Release sets `grant`=0, state IDLE, `slot` <= slot+1 mod 8.
  - `timeout` pulses only when hold counter == HOLD_MAX and `done[g]`=0.
  - No release: hold counter increments.
  - `done` bits of non-granted requesters are ignored.
  - `req[g]` dropping without `done` does not release; only timeout ends the grant.
- Slot wrap: 7 -> 0, with no idle bubble beyond the normal one.
- Config writes:
  - `cfg_we`=1 writes table[cfg_slot] at the edge. The new value is visible from the next cycle.
  - A write to the currently granted slot does not alter the active grant.
  - A write in the same cycle the slot is evaluated uses the old value.
  - A `cfg_owner` value ≥ NUM_REQ is ignored (entry unchanged).
- `busy` = |grant, registered.

## Timing
- Request latency: `req` sampled in IDLE at edge t gives `grant` high after edge t. That is one cycle of latency from the cycle the owner's slot is current.
- Grant length is 1..HOLD_MAX cycles. If `done` is asserted in the first grant cycle, `grant` is high for exactly 1 cycle.
- After every release there is one mandatory IDLE cycle before the next grant.
- Minimum slot period: 1 cycle (unowned/idle) or 2..HOLD_MAX+1 cycles (granted).
- Asynchronous reset mid-grant clears `grant` immediately, without waiting for a clock edge. The first grant after reset deassertion can appear at the first edge after `reset` returns to 1.

## Configuration
- `SLOT_RECLAIM_EN` defined (work-conserving):
  - In IDLE, when the owner is not requesting, the slot is given to the first requesting index found scanning from the round-robin pointer upward (mod NUM_REQ).
  - The pointer then advances to winner+1.
  - The reclaimed grant follows the same GRANT rules. `slot` advances at its release.
- Not defined (strict TDM): an unrequested slot is skipped (slot+1). Non-owners are never granted and the pointer logic is absent.

## Structure
- Package `slot_sched_pkg`:
  - state enum {IDLE, GRANT}
  - `NUM_SLOTS`=8 and slot width 3
  - default-table function (i mod NUM_REQ)
  - one-hot encode helper
- Sub-module `rr_picker` (req vector + pointer -> valid + winner index). It is instantiated only under `SLOT_RECLAIM_EN`.

## Test plan
- Reset default, all `req`=4'b1111, no `done`, HOLD_MAX=4:
  - grants cycle 0001, 0010, 0100, 1000, 0001…
  - each grant lasts 4 cycles with `timeout` pulse at each release
  - `slot` goes 0..7 then wraps to 0.
- Only `req[2]`=1, `done[2]` pulsed in its first grant cycle:
  - grant 0100 for 1 cycle at slots 2 and 6 only
  - without macro, all other slots advance in 1 cycle.
- Reclaim with `SLOT_RECLAIM_EN`, only `req[3]`=1: every slot grants 1000 and the pointer wraps to 0.
- Config: write slot 5 owner 1 while slot 5 is granted to requester 1's rival. The active grant is unchanged. Next lap, slot 5 grants 0010.
- Assert `reset`=0 mid-grant (grant=0100, hold count 2): `grant`, `busy`, `slot` go to 0 asynchronously, and the table returns to its defaults.
- `done[0]` while `grant`=0100, and an out-of-range `cfg_owner`=5 with NUM_REQ=4: the grant still runs to timeout, and the table is unchanged.
